// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM arbiter: data word, RAM handshake state, grant FSM state.
// Pure type/parameter package; no logic, no latency, no backpressure.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side requests plus RAM-side strobes for the arbiter; slave is the arbiter's view.
// Wires only; no latency. Backpressure is the iwait/dwait pair driven by the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      merr;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, merr
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, merr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Grants the single-ported RAM to instruction or data requester, one access at a time.
// 1-cycle arbitration, then RAM-paced access; requesters stall on iwait/dwait until completion.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave arb
);
    import mem_arbiter_pkg::*;

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [CW-1:0] r_starve_cnt;
    logic [CW-1:0] w_starve_nxt;
    logic          r_merr;
    logic          w_merr_nxt;
    logic          w_dreq;
    logic          w_dread;
    logic          w_done;

    assign w_dreq   = arb.dREN | arb.dWEN;
    assign w_dread  = arb.dREN & ~arb.dWEN;
    assign w_done   = (arb.ramstate == ACCESS) || (arb.ramstate == ERROR);
    assign arb.merr = r_merr;

    always_comb begin
        w_next       = r_state;
        w_starve_nxt = r_starve_cnt;
        w_merr_nxt   = r_merr;
        arb.ramREN   = 1'b0;
        arb.ramWEN   = 1'b0;
        arb.ramaddr  = '0;
        arb.ramstore = '0;
        arb.iwait    = 1'b1;
        arb.dwait    = 1'b1;
        arb.iload    = '0;
        arb.dload    = '0;
        case (r_state)
            IDLE: begin
                if (w_dreq && arb.iREN)
                    w_next = (r_starve_cnt == SMAX) ? IGNT : DGNT;
                else if (w_dreq)
                    w_next = DGNT;
                else if (arb.iREN)
                    w_next = IGNT;
            end
            IGNT: begin
                // Strobe follows iREN so a dropped request releases the RAM in the same cycle.
                arb.ramREN  = arb.iREN;
                arb.ramaddr = arb.iaddr;
                if (w_done) begin
                    arb.iwait    = 1'b0;
                    arb.iload    = arb.ramload;
                    w_starve_nxt = '0;
                    w_merr_nxt   = r_merr | (arb.ramstate == ERROR);
                    w_next       = IDLE;
                end else if (!arb.iREN) begin
                    w_next = IDLE;
                end
            end
            DGNT: begin
                arb.ramWEN   = arb.dWEN;
                arb.ramREN   = w_dread;
                arb.ramaddr  = arb.daddr;
                arb.ramstore = arb.dstore;
                if (w_done) begin
                    arb.dwait  = 1'b0;
                    arb.dload  = w_dread ? arb.ramload : '0;
                    w_merr_nxt = r_merr | (arb.ramstate == ERROR);
                    w_next     = IDLE;
                    if (!arb.iREN)
                        w_starve_nxt = '0;
                    else if (r_starve_cnt != SMAX)
                        w_starve_nxt = r_starve_cnt + CW'(1);
                end else if (!w_dreq) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_merr       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_starve_cnt <= w_starve_nxt;
            r_merr       <= w_merr_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives requests and RAM responses cycle by cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic CLK;
    logic nRST;
    int   n_tests;
    int   n_fail;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .arb  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and let the caller drive inputs just after the edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nRST    = 1'b0;
        idle_inputs();

        // Reset values
        sample();
        chk("rst_ramREN",  32'(bus.ramREN), 32'd0);
        chk("rst_ramWEN",  32'(bus.ramWEN), 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_iwait",   32'(bus.iwait), 32'd1);
        chk("rst_dwait",   32'(bus.dwait), 32'd1);
        chk("rst_merr",    32'(bus.merr), 32'd0);
        nRST = 1'b1;

        // Instruction-only fetch, two BUSY cycles then ACCESS
        next_cycle();
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        sample();
        chk("if_arb_ramREN", 32'(bus.ramREN), 32'd0);
        next_cycle();
        bus.ramstate = BUSY;
        sample();
        chk("if_c1_ramREN", 32'(bus.ramREN), 32'd1);
        chk("if_c1_addr",   bus.ramaddr, 32'h40);
        chk("if_c1_iwait",  32'(bus.iwait), 32'd1);
        next_cycle();
        sample();
        chk("if_c2_ramREN", 32'(bus.ramREN), 32'd1);
        chk("if_c2_iwait",  32'(bus.iwait), 32'd1);
        next_cycle();
        bus.ramstate = ACCESS; bus.ramload = 32'h8C010004;
        sample();
        chk("if_c3_ramREN", 32'(bus.ramREN), 32'd1);
        chk("if_c3_iwait",  32'(bus.iwait), 32'd0);
        chk("if_c3_iload",  bus.iload, 32'h8C010004);
        next_cycle();
        idle_inputs();
        sample();
        chk("if_done_ramREN", 32'(bus.ramREN), 32'd0);
        chk("if_done_iwait",  32'(bus.iwait), 32'd1);
        chk("if_done_iload",  bus.iload, 32'd0);

        // Simultaneous requests: data wins, bubble, then instruction
        next_cycle();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        bus.ramstate = ACCESS; bus.ramload = 32'h1234;
        sample();
        next_cycle();
        sample();
        chk("sim_d_ramWEN",   32'(bus.ramWEN), 32'd1);
        chk("sim_d_ramREN",   32'(bus.ramREN), 32'd0);
        chk("sim_d_addr",     bus.ramaddr, 32'h100);
        chk("sim_d_store",    bus.ramstore, 32'hDEADBEEF);
        chk("sim_d_dwait",    32'(bus.dwait), 32'd0);
        chk("sim_d_dload",    bus.dload, 32'd0);
        chk("sim_d_iwait",    32'(bus.iwait), 32'd1);
        next_cycle();
        bus.dWEN = 1'b0;
        sample();
        chk("sim_bub_ramREN", 32'(bus.ramREN), 32'd0);
        chk("sim_bub_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("sim_bub_cnt",    32'(dut.r_starve_cnt), 32'd1);
        next_cycle();
        sample();
        chk("sim_i_ramREN", 32'(bus.ramREN), 32'd1);
        chk("sim_i_addr",   bus.ramaddr, 32'h44);
        chk("sim_i_iwait",  32'(bus.iwait), 32'd0);
        chk("sim_i_iload",  bus.iload, 32'h1234);
        next_cycle();
        idle_inputs();
        sample();
        chk("sim_cnt_clr", 32'(dut.r_starve_cnt), 32'd0);

        // Starvation: four data completions, then instruction is forced
        next_cycle();
        bus.iREN = 1'b1; bus.iaddr = 32'h60;
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        bus.ramstate = ACCESS; bus.ramload = 32'hA5;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk($sformatf("stv_idle%0d_ramREN", k), 32'(bus.ramREN), 32'd0);
            next_cycle();
            sample();
            chk($sformatf("stv_d%0d_addr", k),  bus.ramaddr, 32'h200);
            chk($sformatf("stv_d%0d_dwait", k), 32'(bus.dwait), 32'd0);
            chk($sformatf("stv_d%0d_dload", k), bus.dload, 32'hA5);
            next_cycle();
        end
        sample();
        chk("stv_cnt_max", 32'(dut.r_starve_cnt), 32'd4);
        next_cycle();
        sample();
        chk("stv_i_addr",  bus.ramaddr, 32'h60);
        chk("stv_i_iwait", 32'(bus.iwait), 32'd0);
        chk("stv_i_dwait", 32'(bus.dwait), 32'd1);
        next_cycle();
        idle_inputs();
        sample();
        chk("stv_cnt_clr", 32'(dut.r_starve_cnt), 32'd0);

        // Abort: one data completion with iREN high (cnt=1), then abort a BUSY data grant
        next_cycle();
        bus.iREN = 1'b1; bus.iaddr = 32'h70;
        bus.dREN = 1'b1; bus.daddr = 32'h210;
        bus.ramstate = ACCESS;
        sample();
        next_cycle();
        sample();
        next_cycle();
        bus.ramstate = BUSY;
        sample();
        next_cycle();
        sample();
        chk("ab_grant_ramREN", 32'(bus.ramREN), 32'd1);
        next_cycle();
        bus.dREN = 1'b0;
        sample();
        chk("ab_ramREN", 32'(bus.ramREN), 32'd0);
        chk("ab_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("ab_dwait",  32'(bus.dwait), 32'd1);
        next_cycle();
        bus.iREN = 1'b0;
        sample();
        chk("ab_idle_ramREN", 32'(bus.ramREN), 32'd0);
        chk("ab_idle_dwait",  32'(bus.dwait), 32'd1);
        chk("ab_cnt_kept",    32'(dut.r_starve_cnt), 32'd1);
        chk("ab_merr",        32'(bus.merr), 32'd0);

        // ERROR response on instruction fetch; merr sticks through a good data read
        next_cycle();
        idle_inputs();
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        sample();
        next_cycle();
        bus.ramstate = ERROR; bus.ramload = 32'h77;
        sample();
        chk("err_iwait", 32'(bus.iwait), 32'd0);
        chk("err_iload", bus.iload, 32'h77);
        next_cycle();
        idle_inputs();
        bus.dREN = 1'b1; bus.daddr = 32'h300;
        sample();
        chk("err_merr_set", 32'(bus.merr), 32'd1);
        next_cycle();
        bus.ramstate = ACCESS; bus.ramload = 32'h55;
        sample();
        chk("err_good_dwait", 32'(bus.dwait), 32'd0);
        chk("err_good_dload", bus.dload, 32'h55);
        next_cycle();
        idle_inputs();
        sample();
        chk("err_merr_stick", 32'(bus.merr), 32'd1);

        // Async reset in the middle of a data write grant
        next_cycle();
        bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h1111;
        sample();
        next_cycle();
        bus.ramstate = BUSY;
        sample();
        chk("rmid_ramWEN_pre", 32'(bus.ramWEN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rmid_ramWEN",   32'(bus.ramWEN), 32'd0);
        chk("rmid_ramaddr",  bus.ramaddr, 32'd0);
        chk("rmid_ramstore", bus.ramstore, 32'd0);
        chk("rmid_dwait",    32'(bus.dwait), 32'd1);
        chk("rmid_iwait",    32'(bus.iwait), 32'd1);
        chk("rmid_merr",     32'(bus.merr), 32'd0);
        idle_inputs();
        next_cycle();
        nRST = 1'b1;
        sample();
        chk("rmid_after_ramREN", 32'(bus.ramREN), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-ported RAM between the instruction-fetch requester (fetch stage via icache) and the data requester (memory stage via dcache). It sits between the caches and the RAM model. Requests are granted one at a time through a registered grant state machine. A starvation counter bounds how long instruction fetch can be held off by back-to-back data traffic.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while an instruction request is pending before instruction is forced.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address (word_t)
- dREN  in  1  data read request
- dWEN  in  1  data write request; dREN&&dWEN treated as write
- daddr  in  32  data address
- dstore  in  32  data write value
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- iwait  out  1  low for exactly the completing cycle of an instruction access
- dwait  out  1  low for exactly the completing cycle of a data access
- iload  out  32  ramload when instruction access completes, else 0
- dload  out  32  ramload when data read completes, else 0
- merr  out  1  sticky: a granted access saw ramstate ERROR

## Operation
- States: IDLE, IGNT, DGNT (arb_state_t).
- IDLE: RAM strobes 0, ramaddr/ramstore 0, iwait=dwait=1. Next state:
  - dreq (dREN|dWEN) only -> DGNT; iREN only -> IGNT.
  - both: DGNT unless starve_cnt == STARVE_MAX, then IGNT.
  - none: stay.
- IGNT: ramREN=1, ramaddr=iaddr.
  - ramstate ACCESS or ERROR: iwait=0, iload=ramload, next IDLE.
  - BUSY/FREE: hold.
  - iREN dropped: strobes 0 this cycle, next IDLE (abort), no completion.
- DGNT: ramWEN=dWEN, ramREN=dREN&&!dWEN, ramaddr=daddr, ramstore=dstore.
  - ACCESS/ERROR: dwait=0, dload=ramload if read, else 0; next IDLE.
  - BUSY/FREE: hold.
  - dREN and dWEN both dropped: abort as above.
- starve_cnt, width $clog2(STARVE_MAX+1):
  - +1 on each DGNT completion while iREN high, saturating at STARVE_MAX.
  - cleared on any IGNT completion.
  - cleared on any DGNT completion with iREN low.
- merr set on any completion with ERROR; cleared only by reset.
- Outputs in IGNT/DGNT are combinational from state + ramstate; wait/load never asserted in IDLE.

## Timing
- Reset (async): state IDLE, starve_cnt 0, merr 0.
- Reset output values: all strobes 0, ramaddr/ramstore/iload/dload 0, iwait=dwait=1.
- Arbitration latency: 1 cycle (request seen in IDLE, strobes driven next cycle).
- Access latency = 1 + RAM cycles until ACCESS; minimum 2 cycles request-to-completion.
- Back-to-back requests: one IDLE bubble between consecutive accesses.
- Requester must hold request/address/data stable until its wait goes low; a change mid-grant is forwarded to RAM unregistered.
- Request dropped on the completion cycle with ACCESS: counts as completed, not aborted.
- Reset mid-access: strobes drop immediately; no completion is reported.

## Structure
- cpu_types_pkg: word_t, ramstate_t (existing); add arb_state_t.
- Single module; starve_cnt and state register in one always_ff; next-state and output logic in one always_comb.
- No sub-module required.

## Test plan
- Instruction-only fetch: iREN=1, iaddr=0x40, RAM answers ACCESS after 2 BUSY cycles with 0x8C010004 -> ramREN high cycles 1-3, iwait low only cycle 3, iload=0x8C010004.
- Simultaneous requests: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> data granted first (ramWEN, ramstore=0xDEADBEEF), then IDLE bubble, then instruction granted.
- Starvation: iREN held high, dREN reasserted every idle cycle, STARVE_MAX=4 -> exactly 4 data completions, then IGNT, then starve_cnt back to 0.
- Abort: DGNT with RAM BUSY, drop dREN -> strobes 0 same cycle, IDLE next, dwait never low, starve_cnt unchanged.
- ERROR response: ramstate=ERROR during IGNT -> iwait low one cycle, merr=1 and stays 1 across later good accesses.
- Async reset mid-DGNT: nRST low while ramWEN=1 -> ramWEN 0 immediately, all outputs at reset values, merr 0.
